seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//  Holds a shadow copy of BCD digits and decimal points, steps one digit per slot,
//  and drives active-low anodes and cathodes. Inserts dead time between slots to
//  prevent ghosting. New values are accepted only at frame boundaries, so no tearing.
// PARAMETERS
//  N_DIGITS   4       digits scanned, legal 1..8
//  TICK_DIV   100000  clk cycles per digit slot (SHOW + BLANK)
//  BLANK_CYC  16      dead-time cycles per slot, legal 1..TICK_DIV-1
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous reset, active-high
//  enable       in   1           1 = scan; 0 = display dark
//  value_in     in   4*N_DIGITS  BCD digits; digit k = value_in[4k+3:4k], digit 0 = rightmost
//  dp_in        in   N_DIGITS    decimal point per digit, 1 = lit
//  load_req     in   1           level; value_in/dp_in stable while high
//  load_ack     out  1           1-cycle pulse: shadow regs captured value_in/dp_in
//  frame_start  out  1           1-cycle pulse on entry to SHOW for digit 0
//  anode        out  N_DIGITS    active-low digit enables
//  cathode      out  8           active-low segments, [7]=DP, [6:0]=g..a
// BEHAVIOUR
//  Reset: state IDLE, idx 0, slot counter 0, shadows 0. Outputs: anode all 1,
//   cathode 8'hFF, load_ack 0, frame_start 0. Reset mid-slot aborts immediately;
//   a pending load_req is not acked.
//  FSM IDLE/BLANK/SHOW, all outputs registered (1-cycle latency from state/idx).
//  IDLE: dark. If load_req, capture shadows and pulse load_ack next cycle.
//   On enable=1 go to BLANK with idx 0.
//  BLANK: BLANK_CYC cycles. anode all 1, cathode 8'hFF. Then go to SHOW.
//   frame_start pulses on the cycle SHOW is entered with idx 0.
//  SHOW: TICK_DIV-BLANK_CYC cycles. anode[idx]=0, others 1.
//   cathode = {~dp_sh[idx], seg(dig_sh[idx])}.
//   On the final cycle: idx <= (idx==N_DIGITS-1) ? 0 : idx+1, then go to BLANK.
//  Frame boundary = the SHOW->BLANK transition where idx wraps to 0.
//   If load_req=1 at that cycle, capture shadows and pulse load_ack.
//   load_req held high mid-frame waits; no partial update.
//  enable=0 in any state: go to IDLE next cycle, outputs dark, idx and counter cleared.
//  seg(): active-low; 0..9 standard patterns (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30,
//   4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10).
//   Codes 10..15 = 7'h7F (blank).
//  Slot counter width = $clog2(TICK_DIV); it wraps to 0 at slot end.
//   Total frame = N_DIGITS*TICK_DIV cycles.
// CONFIGURATION
//  SEVEN_SEG_LZB_EN defined: leading-zero blanking. Digits above the highest
//   non-zero digit are dark for their whole slot (anode all 1, cathode 8'hFF,
//   DP ignored). Digit 0 is never blanked. The slot timing is unchanged.
//  Not defined: every digit is shown in its slot.
// STRUCTURE
//  Package seven_seg_pkg holds:
//   - state enum {IDLE, BLANK, SHOW}
//   - CATH_OFF = 8'hFF
//   - 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK
//  Sub-module bcd_seg_lut: combinational 4-bit -> 7-bit seg() table, shared with
//   other display blocks. The FSM, counters, shadows and LZB mask live in this module.
// TESTING (N_DIGITS=4, TICK_DIV=8, BLANK_CYC=2)
//  1 Reset: rst high 3 cycles with load_req=1 -> anode 4'hF, cathode 8'hFF, no load_ack.
//  2 Scan: load 16'h1234, dp 4'b0000, enable.
//     Slots repeat BLANK 2 cycles, SHOW 6 cycles.
//     Anodes in order 1110, 1101, 1011, 0111; cathodes 8'h99, 8'hB0, 8'hA4, 8'hF9.
//     frame_start every 32 cycles.
//  3 Mid-frame load: load_req with 16'h5678 during digit-1 SHOW -> display keeps
//     1234 until the wrap. load_ack pulses once at the wrap; next slot 0 = 8'h80.
//  4 dp_in=4'b0010 -> digit-1 cathode[7]=0, others cathode[7]=1.
//     enable dropped mid-SHOW -> dark next cycle. Re-enable restarts at digit 0
//     after 2 blank cycles.
//  5 LZB: value 16'h0050.
//     With SEVEN_SEG_LZB_EN: anode[3:2] never low; digit 1 = 8'h92, digit 0 = 8'hC0.
//     Without: all four anodes pulse; digits 3,2 show 8'hC0.
//  6 Reset during digit-2 SHOW with load_req pending -> reset values next cycle,
//     no load_ack. Shadows read 0 after re-enable.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and segment constants for the 7-segment display blocks.
// Segment patterns are active-low, bit order g..a.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam logic [7:0] CATH_OFF = 8'hFF;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_seg_lut.sv
// BCD to active-low 7-segment lookup; codes 10..15 render blank.
// Purely combinational, shared by the display blocks.
module bcd_seg_lut
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load_req,
  output logic                  load_ack,
  output logic                  frame_start,
  output logic [N_DIGITS-1:0]   anode,
  output logic [7:0]            cathode
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_1ST = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE   = N_DIGITS'(1);

  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_ndig
    $error("N_DIGITS out of range");
  end
  if (BLANK_CYC < 1 || BLANK_CYC >= TICK_DIV) begin : g_bad_blank
    $error("BLANK_CYC out of range");
  end

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         dig_sh [N_DIGITS];
  logic [N_DIGITS-1:0] dp_sh;

  logic [3:0]          cur_dig;
  logic [6:0]          cur_seg;
  logic [N_DIGITS-1:0] dark;
  logic                wrap;
  logic                cap;

  assign cur_dig = dig_sh[idx];

  bcd_seg_lut u_lut (
    .bcd (cur_dig),
    .seg (cur_seg)
  );

  // Last cycle of the last digit's SHOW: the only mid-scan load point.
  assign wrap = (state == SHOW) && (cnt == CNT_LAST) && (idx == IDX_LAST);
  assign cap  = load_req && ((state == IDLE) || (enable && wrap));

  always_comb begin
    dark = '0;
`ifdef SEVEN_SEG_LZB_EN
    begin : lzb
      logic run;
      run = 1'b1;
      for (int k = N_DIGITS - 1; k > 0; k--) begin
        run     = run && (dig_sh[k] == 4'd0);
        dark[k] = run;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_sh    <= '0;
      load_ack <= 1'b0;
      for (int k = 0; k < N_DIGITS; k++) begin
        dig_sh[k] <= 4'd0;
      end
    end else begin
      load_ack <= cap;
      if (cap) begin
        dp_sh <= dp_in;
        for (int k = 0; k < N_DIGITS; k++) begin
          dig_sh[k] <= value_in[4*k +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      anode       <= '1;
      cathode     <= CATH_OFF;
      frame_start <= 1'b0;
    end else begin
      anode       <= '1;
      cathode     <= CATH_OFF;
      frame_start <= 1'b0;

      if (enable && state == SHOW && !dark[idx]) begin
        anode   <= ~(ONE << idx);
        cathode <= {~dp_sh[idx], cur_seg};
      end

      if (!enable) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= BLANK;
            idx   <= '0;
            cnt   <= '0;
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLK_LAST) begin
              state <= SHOW;
              if (idx == '0) frame_start <= 1'b1;
            end
          end
          SHOW: begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= BLANK;
              idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank).
// Honours SEVEN_SEG_LZB_EN the same way the design does.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load_req;
  logic        load_ack;
  logic        frame_start;
  logic [3:0]  anode;
  logic [7:0]  cathode;

  int nvec = 0;
  int nerr = 0;

  // k counts cycles since the scan left IDLE (0 = IDLE)
  int         k = 0;
  logic [7:0] cur_cath [4];
  logic [7:0] pend_cath [4];
  logic [3:0] cur_dark;
  logic [3:0] pend_dark;
  logic [3:0] exp_an;
  logic [7:0] exp_cath;
  logic       exp_fs;
  logic       exp_ack;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .N_DIGITS  (4),
    .TICK_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .load_req    (load_req),
    .load_ack    (load_ack),
    .frame_start (frame_start),
    .anode       (anode),
    .cathode     (cathode)
  );

  task automatic step();
    logic lr, en, bnd;
    int   c, d;
    lr = load_req;
    en = enable;
    c  = (k - 1) % 8;
    d  = ((k - 1) / 8) % 4;
    bnd      = (k >= 1) && (c == 7) && (d == 3);
    exp_ack  = lr && (k == 0 || (en && bnd));
    exp_an   = 4'hF;
    exp_cath = 8'hFF;
    if (en && k >= 1 && c >= 2 && !cur_dark[d]) begin
      exp_an   = ~(4'b0001 << d);
      exp_cath = cur_cath[d];
    end
    @(posedge clk);
    #1;
    if (exp_ack) begin
      cur_cath = pend_cath;
      cur_dark = pend_dark;
    end
    k = en ? k + 1 : 0;
    c = (k - 1) % 8;
    d = ((k - 1) / 8) % 4;
    exp_fs = en && (k >= 1) && (c == 2) && (d == 0);
  endtask

  function automatic logic at_slot(input int dig, input int pos);
    return (k >= 1) && ((k - 1) % 8 == pos) && (((k - 1) / 8) % 4 == dig);
  endfunction

  task automatic test_reset();
    rst      = 1'b1;
    enable   = 1'b0;
    load_req = 1'b1;
    value_in = 16'h9876;
    dp_in    = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      nvec++;
      if ({anode, cathode, load_ack, frame_start} !== {4'hF, 8'hFF, 2'b00}) begin
        nerr++;
        $display("FAIL reset cyc%0d got an=%h ca=%h ack=%b fs=%b, exp an=f ca=ff ack=0 fs=0",
                 i, anode, cathode, load_ack, frame_start);
      end
    end
    rst      = 1'b0;
    load_req = 1'b0;
    k        = 0;
    cur_dark = 4'h0;
    for (int i = 0; i < 4; i++) cur_cath[i] = 8'hC0;
  endtask

  task automatic test_scan();
    value_in  = 16'h1234;
    dp_in     = 4'b0000;
    load_req  = 1'b1;
    pend_cath = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    pend_dark = 4'h0;
    step();
    nvec++;
    if (load_ack !== 1'b1) begin
      nerr++;
      $display("FAIL idle_load ack got %b exp 1", load_ack);
    end
    load_req = 1'b0;
    enable   = 1'b1;
    for (int i = 0; i < 70; i++) begin
      step();
      nvec++;
      if ({anode, cathode, frame_start, load_ack} !== {exp_an, exp_cath, exp_fs, exp_ack}) begin
        nerr++;
        $display("FAIL scan k=%0d got an=%h ca=%h fs=%b ack=%b exp an=%h ca=%h fs=%b ack=%b",
                 k, anode, cathode, frame_start, load_ack, exp_an, exp_cath, exp_fs, exp_ack);
      end
    end
  endtask

  task automatic test_midframe_load();
    int acks = 0;
    for (int i = 0; i < 40 && !at_slot(1, 3); i++) begin
      step();
      nvec++;
      if ({anode, cathode, frame_start, load_ack} !== {exp_an, exp_cath, exp_fs, exp_ack}) begin
        nerr++;
        $display("FAIL mid_pre k=%0d got an=%h ca=%h fs=%b ack=%b exp an=%h ca=%h fs=%b ack=%b",
                 k, anode, cathode, frame_start, load_ack, exp_an, exp_cath, exp_fs, exp_ack);
      end
    end
    value_in  = 16'h5678;
    load_req  = 1'b1;
    pend_cath = '{8'h80, 8'hF8, 8'h82, 8'h92};
    for (int i = 0; i < 48; i++) begin
      step();
      if (load_ack === 1'b1) acks++;
      nvec++;
      if ({anode, cathode, frame_start, load_ack} !== {exp_an, exp_cath, exp_fs, exp_ack}) begin
        nerr++;
        $display("FAIL mid_load k=%0d got an=%h ca=%h fs=%b ack=%b exp an=%h ca=%h fs=%b ack=%b",
                 k, anode, cathode, frame_start, load_ack, exp_an, exp_cath, exp_fs, exp_ack);
      end
      if (exp_ack) load_req = 1'b0;
    end
    nvec++;
    if (acks != 1) begin
      nerr++;
      $display("FAIL mid_ack_count got %0d exp 1", acks);
    end
  endtask

  task automatic test_dp_enable();
    dp_in     = 4'b0010;
    load_req  = 1'b1;
    pend_cath = '{8'h80, 8'h78, 8'h82, 8'h92};
    for (int i = 0; i < 72; i++) begin
      step();
      nvec++;
      if ({anode, cathode, frame_start, load_ack} !== {exp_an, exp_cath, exp_fs, exp_ack}) begin
        nerr++;
        $display("FAIL dp k=%0d got an=%h ca=%h fs=%b ack=%b exp an=%h ca=%h fs=%b ack=%b",
                 k, anode, cathode, frame_start, load_ack, exp_an, exp_cath, exp_fs, exp_ack);
      end
      if (exp_ack) load_req = 1'b0;
    end
    for (int i = 0; i < 40 && !at_slot(2, 4); i++) step();
    enable = 1'b0;
    step();
    nvec++;
    if ({anode, cathode} !== {4'hF, 8'hFF}) begin
      nerr++;
      $display("FAIL disable_dark got an=%h ca=%h exp an=f ca=ff", anode, cathode);
    end
    step();
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      nvec++;
      if ({anode, cathode, frame_start, load_ack} !== {exp_an, exp_cath, exp_fs, exp_ack}) begin
        nerr++;
        $display("FAIL reenable k=%0d got an=%h ca=%h fs=%b ack=%b exp an=%h ca=%h fs=%b ack=%b",
                 k, anode, cathode, frame_start, load_ack, exp_an, exp_cath, exp_fs, exp_ack);
      end
    end
  endtask

  task automatic test_lzb();
    int low32 = 0;
    value_in  = 16'h0050;
    dp_in     = 4'b0000;
    load_req  = 1'b1;
    pend_cath = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
`ifdef SEVEN_SEG_LZB_EN
    pend_dark = 4'b1100;
`else
    pend_dark = 4'b0000;
`endif
    for (int i = 0; i < 80; i++) begin
      step();
      if (anode[3:2] != 2'b11) low32++;
      nvec++;
      if ({anode, cathode, frame_start, load_ack} !== {exp_an, exp_cath, exp_fs, exp_ack}) begin
        nerr++;
        $display("FAIL lzb k=%0d got an=%h ca=%h fs=%b ack=%b exp an=%h ca=%h fs=%b ack=%b",
                 k, anode, cathode, frame_start, load_ack, exp_an, exp_cath, exp_fs, exp_ack);
      end
      if (exp_ack) load_req = 1'b0;
    end
    nvec++;
`ifdef SEVEN_SEG_LZB_EN
    if (low32 != 0) begin
      nerr++;
      $display("FAIL lzb_upper_anodes got %0d low cycles exp 0", low32);
    end
`else
    if (low32 == 0) begin
      nerr++;
      $display("FAIL lzb_upper_anodes got 0 low cycles exp >0");
    end
`endif
  endtask

  task automatic test_reset_midslot();
    for (int i = 0; i < 40 && !at_slot(2, 4); i++) step();
    rst      = 1'b1;
    load_req = 1'b1;
    value_in = 16'h9999;
    @(posedge clk);
    #1;
    nvec++;
    if ({anode, cathode, load_ack, frame_start} !== {4'hF, 8'hFF, 2'b00}) begin
      nerr++;
      $display("FAIL reset_mid got an=%h ca=%h ack=%b fs=%b exp an=f ca=ff ack=0 fs=0",
               anode, cathode, load_ack, frame_start);
    end
    rst      = 1'b0;
    load_req = 1'b0;
    k        = 0;
    for (int i = 0; i < 4; i++) cur_cath[i] = 8'hC0;
`ifdef SEVEN_SEG_LZB_EN
    cur_dark = 4'b1110;
`else
    cur_dark = 4'b0000;
`endif
    for (int i = 0; i < 40; i++) begin
      step();
      nvec++;
      if ({anode, cathode, frame_start, load_ack} !== {exp_an, exp_cath, exp_fs, exp_ack}) begin
        nerr++;
        $display("FAIL post_reset k=%0d got an=%h ca=%h fs=%b ack=%b exp an=%h ca=%h fs=%b ack=%b",
                 k, anode, cathode, frame_start, load_ack, exp_an, exp_cath, exp_fs, exp_ack);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_dp_enable();
    test_lzb();
    test_reset_midslot();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
